// File: rtl/adv_timer_cfg_sched_pkg.sv
// Shared types and limits for the advanced-timer configuration scheduler.
package adv_timer_cfg_sched_pkg;

  localparam int N_REQ_MIN  = 2;
  localparam int N_REQ_MAX  = 8;
  localparam int SETTLE_MAX = 15;
  // Widest counter the payload struct can carry; narrower timers use the low bits.
  localparam int CNT_W_MAX  = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STOP   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_START  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] cnt_start;
    logic [CNT_W_MAX-1:0] cnt_end;
    logic [7:0]           presc;
    logic [2:0]           mode;
    logic                 restart;
  } req_payload_t;

endpackage

// File: rtl/adv_timer_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr_i upward (wrapping) and
// grants the first active request. The pointer register lives in the parent.
module adv_timer_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // First active request at or after the pointer wins.
  always_comb begin : p_arb
    int k;
    k       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      k = (int'(ptr_i) + off) % N_REQ;
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/adv_timer_cfg_sched.sv
// Configuration scheduler in front of one advanced-timer counter block.
// Picks a requester round-robin, latches its payload, then drives the timer
// control plane: stop, atomic config load, optional settle gap, start.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for any request; grant + payload capture happen here
// ST_STOP   | stop pulse to the timer is high
// ST_LOAD   | update pulse high, cfg data outputs carry the new config
// ST_SETTLE | quiet gap, down-counter runs to 0
// ST_START  | start pulse (if restart requested) and done pulse high
//
// Command pulses are registered: each is set on the edge that enters its state.
module adv_timer_cfg_sched
  import adv_timer_cfg_sched_pkg::*;
#(
  parameter int NUM_BITS      = 16,
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*NUM_BITS-1:0] req_cnt_start_i,
  input  logic [N_REQ*NUM_BITS-1:0] req_cnt_end_i,
  input  logic [N_REQ*8-1:0]        req_presc_i,
  input  logic [N_REQ*3-1:0]        req_mode_i,
  input  logic [N_REQ-1:0]          req_restart_i,
  output logic                      cfg_stop_o,
  output logic                      cfg_update_o,
  output logic                      cfg_start_o,
  output logic [NUM_BITS-1:0]       cfg_cnt_start_o,
  output logic [NUM_BITS-1:0]       cfg_cnt_end_o,
  output logic [7:0]                cfg_presc_o,
  output logic [2:0]                cfg_mode_o,
  output logic                      busy_o,
  output logic [IDX_W-1:0]          owner_o,
  output logic                      done_o
);

  sched_state_e        r_state;
  logic [IDX_W-1:0]    r_rr;
  logic [IDX_W-1:0]    r_owner;
  logic [3:0]          r_settle_cnt;
  req_payload_t        r_shadow;
  logic                r_stop;
  logic                r_update;
  logic                r_start;
  logic                r_done;
  logic [NUM_BITS-1:0] r_cnt_start;
  logic [NUM_BITS-1:0] r_cnt_end;
  logic [7:0]          r_presc;
  logic [2:0]          r_mode;

  logic [N_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]    w_idx;
  logic                w_arb_valid;
  logic                w_grant;
  req_payload_t        w_sel;
  logic [IDX_W-1:0]    w_rr_next;

  adv_timer_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (r_rr),
    .gnt_o   (w_gnt),
    .idx_o   (w_idx),
    .valid_o (w_arb_valid)
  );

  assign w_grant     = (r_state == ST_IDLE) && w_arb_valid;
  assign req_ready_o = (r_state == ST_IDLE) ? w_gnt : '0;
  assign w_rr_next   = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

  // Winner's payload slices, widened into the shared struct layout.
  always_comb begin
    w_sel           = '0;
    w_sel.cnt_start = CNT_W_MAX'(req_cnt_start_i[int'(w_idx)*NUM_BITS +: NUM_BITS]);
    w_sel.cnt_end   = CNT_W_MAX'(req_cnt_end_i[int'(w_idx)*NUM_BITS +: NUM_BITS]);
    w_sel.presc     = req_presc_i[int'(w_idx)*8 +: 8];
    w_sel.mode      = req_mode_i[int'(w_idx)*3 +: 3];
    w_sel.restart   = req_restart_i[w_idx];
  end

  // Sequencer: state, arbitration pointer, shadow payload and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_rr         <= '0;
      r_owner      <= '0;
      r_settle_cnt <= '0;
      r_shadow     <= '0;
      r_stop       <= 1'b0;
      r_update     <= 1'b0;
      r_start      <= 1'b0;
      r_done       <= 1'b0;
      r_cnt_start  <= '0;
      r_cnt_end    <= '0;
      r_presc      <= '0;
      r_mode       <= '0;
    end else begin
      r_stop   <= 1'b0;
      r_update <= 1'b0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_shadow <= w_sel;
            r_owner  <= w_idx;
            r_rr     <= w_rr_next;
            r_stop   <= 1'b1;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_cnt_start <= r_shadow.cnt_start[NUM_BITS-1:0];
          r_cnt_end   <= r_shadow.cnt_end[NUM_BITS-1:0];
          r_presc     <= r_shadow.presc;
          r_mode      <= r_shadow.mode;
          r_update    <= 1'b1;
          r_state     <= ST_LOAD;
        end
        ST_LOAD: begin
          if (SETTLE_CYCLES > 0) begin
            r_settle_cnt <= 4'(SETTLE_CYCLES - 1);
            r_state      <= ST_SETTLE;
          end else begin
            r_start <= r_shadow.restart;
            r_done  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_start <= r_shadow.restart;
            r_done  <= 1'b1;
            r_state <= ST_START;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        ST_START: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_stop_o      = r_stop;
  assign cfg_update_o    = r_update;
  assign cfg_start_o     = r_start;
  assign done_o          = r_done;
  assign cfg_cnt_start_o = r_cnt_start;
  assign cfg_cnt_end_o   = r_cnt_end;
  assign cfg_presc_o     = r_presc;
  assign cfg_mode_o      = r_mode;
  assign busy_o          = (r_state != ST_IDLE);
  assign owner_o         = r_owner;

endmodule

// File: tb/tb_adv_timer_cfg_sched.sv
// Directed bench for adv_timer_cfg_sched: default build (settle=2) and a
// settle=0 build side by side, sharing clock, reset and payload buses.
module tb_adv_timer_cfg_sched;

  localparam int NB = 16;
  localparam int NR = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [NR-1:0] valid, valid0;
  logic [NR-1:0] ready, ready0;
  logic [NR*NB-1:0] p_start, p_end;
  logic [NR*8-1:0]  p_presc;
  logic [NR*3-1:0]  p_mode;
  logic [NR-1:0]    p_restart;

  logic          stop, update, start, done, busy;
  logic [NB-1:0] c_start, c_end;
  logic [7:0]    c_presc;
  logic [2:0]    c_mode;
  logic [1:0]    owner;

  logic          stop0, update0, start0, done0, busy0;
  logic [NB-1:0] c_start0, c_end0;
  logic [7:0]    c_presc0;
  logic [2:0]    c_mode0;
  logic [1:0]    owner0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_i = ~clk_i;

  adv_timer_cfg_sched #(.NUM_BITS(NB), .N_REQ(NR), .SETTLE_CYCLES(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_cnt_start_i(p_start), .req_cnt_end_i(p_end),
    .req_presc_i(p_presc), .req_mode_i(p_mode), .req_restart_i(p_restart),
    .cfg_stop_o(stop), .cfg_update_o(update), .cfg_start_o(start),
    .cfg_cnt_start_o(c_start), .cfg_cnt_end_o(c_end),
    .cfg_presc_o(c_presc), .cfg_mode_o(c_mode),
    .busy_o(busy), .owner_o(owner), .done_o(done)
  );

  adv_timer_cfg_sched #(.NUM_BITS(NB), .N_REQ(NR), .SETTLE_CYCLES(0)) dut0 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(valid0), .req_ready_o(ready0),
    .req_cnt_start_i(p_start), .req_cnt_end_i(p_end),
    .req_presc_i(p_presc), .req_mode_i(p_mode), .req_restart_i(p_restart),
    .cfg_stop_o(stop0), .cfg_update_o(update0), .cfg_start_o(start0),
    .cfg_cnt_start_o(c_start0), .cfg_cnt_end_o(c_end0),
    .cfg_presc_o(c_presc0), .cfg_mode_o(c_mode0),
    .busy_o(busy0), .owner_o(owner0), .done_o(done0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: land just after the active edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    valid  = '0;
    valid0 = '0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic set_payload(input int i, input logic [15:0] s, input logic [15:0] e,
                             input logic [7:0] p, input logic [2:0] m, input logic r);
    p_start[i*NB +: NB] = s;
    p_end[i*NB +: NB]   = e;
    p_presc[i*8 +: 8]   = p;
    p_mode[i*3 +: 3]    = m;
    p_restart[i]        = r;
  endtask

  // Expected {stop,update,start,done} k cycles after a grant.
  function automatic logic [3:0] exp_cmd(input int k, input int settle, input logic rs);
    if (k == 1) return 4'b1000;
    if (k == 2) return 4'b0100;
    if (k == 3 + settle) return {2'b00, rs, 1'b1};
    return 4'b0000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ready1_seen;
    int start_seen;
    valid = '0; valid0 = '0;
    p_start = '0; p_end = '0; p_presc = '0; p_mode = '0; p_restart = '0;

    // Reset state
    #3;
    chk("rst_cmd",   32'({stop, update, start, done}), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_data",  32'({c_start, c_presc, c_mode}), 32'h0);
    chk("rst_end",   32'(c_end), 32'h0);
    do_reset();

    // Test 1: requester 2, restart=1
    set_payload(2, 16'h0010, 16'h00FF, 8'd3, 3'd1, 1'b1);
    cyc();
    valid = 4'b0100;
    #1;
    chk("t1_ready", 32'(ready), 32'h4);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      valid = '0;
      #1;
      chk($sformatf("t1_cmd_%0d", k), 32'({stop, update, start, done}), 32'(exp_cmd(k, 2, 1'b1)));
      chk($sformatf("t1_busy_%0d", k), 32'(busy), (k <= 5) ? 32'h1 : 32'h0);
      if (k == 1) chk("t1_owner", 32'(owner), 32'h2);
      if (k == 2) begin
        chk("t1_cstart", 32'(c_start), 32'h0010);
        chk("t1_cend",   32'(c_end),   32'h00FF);
        chk("t1_presc",  32'(c_presc), 32'h3);
        chk("t1_mode",   32'(c_mode),  32'h1);
      end
    end

    // Test 2: requester 1, restart=0; old config held until LOAD
    set_payload(1, 16'hABCD, 16'h1234, 8'h80, 3'd5, 1'b0);
    valid = 4'b0010;
    #1;
    chk("t2_ready", 32'(ready), 32'h2);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      valid = '0;
      #1;
      chk($sformatf("t2_cmd_%0d", k), 32'({stop, update, start, done}), 32'(exp_cmd(k, 2, 1'b0)));
      if (k == 1) begin
        chk("t2_owner", 32'(owner), 32'h1);
        chk("t2_hold",  32'(c_start), 32'h0010);
      end
      if (k == 2) begin
        chk("t2_cstart", 32'(c_start), 32'hABCD);
        chk("t2_cend",   32'(c_end),   32'h1234);
        chk("t2_pm",     32'({c_presc, c_mode}), 32'({8'h80, 3'd5}));
      end
    end

    // Test 3: all four valid continuously -> 0,1,2,3,0 six cycles apart
    do_reset();
    cyc();
    valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("t3_grant_%0d", g), 32'(ready), 32'(1 << (g % 4)));
      for (int k = 1; k <= 5; k++) begin
        cyc();
        #1;
        chk($sformatf("t3_rdy0_%0d_%0d", g, k), 32'(ready), 32'h0);
        chk($sformatf("t3_cmd1hot_%0d_%0d", g, k), 32'($countones({stop, update, start}) <= 1), 32'h1);
      end
      if (g == 0) chk("t3_owner0", 32'(owner), 32'h0);
      cyc();
      #1;
    end
    valid = '0;

    // Test 4: settle=0 build, start/done at T+3, next grant at T+4
    do_reset();
    set_payload(0, 16'h0001, 16'h0002, 8'd1, 3'd2, 1'b1);
    set_payload(1, 16'h0003, 16'h0004, 8'd2, 3'd3, 1'b1);
    cyc();
    valid0 = 4'b0011;
    #1;
    chk("t4_ready", 32'(ready0), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      valid0 = 4'b0010;
      #1;
      chk($sformatf("t4_cmd_%0d", k), 32'({stop0, update0, start0, done0}), 32'(exp_cmd(k, 0, 1'b1)));
      chk($sformatf("t4_rdy0_%0d", k), 32'(ready0), 32'h0);
    end
    cyc();
    #1;
    chk("t4_next_grant", 32'(ready0), 32'h2);
    cyc();
    valid0 = '0;

    // Test 5: reset during SETTLE
    do_reset();
    set_payload(2, 16'h0055, 16'h0066, 8'd7, 3'd4, 1'b1);
    cyc();
    valid = 4'b0100;
    #1;
    chk("t5_ready", 32'(ready), 32'h4);
    cyc(); valid = '0;   // T+1
    cyc();               // T+2
    cyc();               // T+3, in SETTLE
    chk("t5_settle_busy", 32'(busy), 32'h1);
    rstn_i = 1'b0;
    #1;
    chk("t5_rst_cmd",  32'({stop, update, start, done}), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_own",  32'(owner), 32'h0);
    chk("t5_rst_cs",   32'(c_start), 32'h0);
    chk("t5_rst_ce",   32'(c_end), 32'h0);
    chk("t5_rst_pm",   32'({c_presc, c_mode}), 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    start_seen = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      #1;
      if (start || done) start_seen++;
    end
    chk("t5_no_start", 32'(start_seen), 32'h0);
    set_payload(0, 16'h0100, 16'h0200, 8'd9, 3'd6, 1'b0);
    set_payload(3, 16'h0300, 16'h0400, 8'd8, 3'd7, 1'b0);
    valid = 4'b1001;
    #1;
    chk("t5_rr_reset", 32'(ready), 32'h1);
    cyc();
    valid = '0;

    // Test 6: requester 1 withdraws while busy; 3 wins next
    do_reset();
    cyc();
    valid = 4'b1011;
    #1;
    chk("t6_ready", 32'(ready), 32'h1);
    ready1_seen = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      valid = (k == 1) ? 4'b1010 : 4'b1000;
      #1;
      if (ready[1]) ready1_seen++;
      if (k < 6) chk($sformatf("t6_rdy0_%0d", k), 32'(ready), 32'h0);
    end
    chk("t6_grant3", 32'(ready), 32'h8);
    chk("t6_no_r1", 32'(ready1_seen), 32'h0);
    cyc();
    valid = '0;
    #1;
    chk("t6_owner", 32'(owner), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
